shuffle_unloader: RTL and testbench

- Downstream counterpart of the shuffle input loader: collects one 4-beat shuffle result burst of 128-bit slices, reassembles the 512-bit word plus nonce, and buffers it in a 2-entry FIFO.
- Presents each word to the implode stage over a four-phase valid/handshake protocol.
- Sits between the shuffle core and implode; decouples shuffle throughput from slow implode acknowledgement.

---
 rtl/shuffle_unloader_pkg.sv | 28 ++
 rtl/shuffle_word_fifo.sv | 43 ++++
 rtl/shuffle_unloader.sv | 128 ++++++++++++
 tb/tb_shuffle_unloader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_unloader_pkg.sv
// rtl/shuffle_unloader_pkg.sv - shared encodings and geometry for the shuffle unloader
package shuffle_unloader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    BEAT3 = 2'd3
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE    = 2'd0,
    O_VALID   = 2'd1,
    O_WAITLOW = 2'd2
  } out_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int NUM_BEATS  = 4;

  function automatic int slice_width(input int ew);
    return ew / 4;
  endfunction

  function automatic int lane_width(input int ew);
    return ew / 8;
  endfunction

endpackage

// File: rtl/shuffle_word_fifo.sv
// rtl/shuffle_word_fifo.sv - two-entry register FIFO holding {nonce, word}
module shuffle_word_fifo
  import shuffle_unloader_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic [1:0]       count
);

  logic [width-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // One-bit pointers wrap naturally for the two slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/shuffle_unloader.sv
// rtl/shuffle_unloader.sv - reassembles 4-beat shuffle bursts and hands words to implode
module shuffle_unloader
  import shuffle_unloader_pkg::*;
#(
  parameter int nonce_width   = 7,
  parameter int explode_width = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_sh_valid,
  output logic                       o_sh_ready,
  input  logic [explode_width/4-1:0] i_sh_data,
  input  logic [nonce_width-1:0]     i_sh_nonce,
  output logic                       o_im_valid,
  input  logic                       i_im_handshake,
  output logic [explode_width-1:0]   o_im_data,
  output logic [nonce_width-1:0]     o_im_nonce
);

  localparam int SW = slice_width(explode_width);
  localparam int LW = lane_width(explode_width);
  localparam int EW = nonce_width + explode_width;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [1:0]               fifo_count;
  logic [1:0]               beat;
  logic                     sh_xfer, capture, push, pop, load;
  logic [explode_width-1:0] word_q, asm_word;
  logic [nonce_width-1:0]   nonce_q;
  logic [EW-1:0]            head_data, push_data, load_data;

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign o_sh_ready = !rst && (in_state == IDLE) && (fifo_count < 2'(FIFO_DEPTH));
  assign sh_xfer    = i_sh_valid && o_sh_ready;
  assign capture    = sh_xfer || (in_state != IDLE);
  assign push       = (in_state == BEAT3);
  assign beat       = in_state;
  assign push_data  = {nonce_q, asm_word};

  always_comb begin
    in_next = in_state;
    case (in_state)
      IDLE:    if (sh_xfer) in_next = BEAT1;
      BEAT1:   in_next = BEAT2;
      BEAT2:   in_next = BEAT3;
      default: in_next = IDLE;
    endcase
  end

  // Upper half of beat k lands in lane k, lower half in lane k+4.
  always_comb begin
    asm_word = word_q;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (beat == 2'(k)) begin
        asm_word[LW*k +: LW]     = i_sh_data[SW-1:LW];
        asm_word[LW*(k+4) +: LW] = i_sh_data[LW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state <= IDLE;
      word_q   <= '0;
      nonce_q  <= '0;
    end else begin
      in_state <= in_next;
      if (capture) word_q <= asm_word;
      if (sh_xfer) nonce_q <= i_sh_nonce;
    end
  end

  shuffle_word_fifo #(
    .width(EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head_data(head_data),
    .count    (fifo_count)
  );

  // An empty FIFO being written this cycle is presented straight from the write data.
  always_comb begin
    out_next  = out_state;
    load      = 1'b0;
    pop       = 1'b0;
    load_data = head_data;
    case (out_state)
      O_IDLE: begin
        if (fifo_count != 2'd0) begin
          load     = 1'b1;
          out_next = O_VALID;
        end else if (push) begin
          load      = 1'b1;
          load_data = push_data;
          out_next  = O_VALID;
        end
      end
      O_VALID: begin
        if (i_im_handshake) begin
          pop      = 1'b1;
          out_next = O_WAITLOW;
        end
      end
      O_WAITLOW: if (!i_im_handshake) out_next = O_IDLE;
      default:   out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state  <= O_IDLE;
      o_im_data  <= '0;
      o_im_nonce <= '0;
    end else begin
      out_state <= out_next;
      if (load) {o_im_nonce, o_im_data} <= load_data;
    end
  end

  assign o_im_valid = (out_state == O_VALID);

endmodule

// File: tb/tb_shuffle_unloader.sv
// tb/tb_shuffle_unloader.sv - directed self-checking bench for shuffle_unloader
module tb_shuffle_unloader;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_sh_valid;
  logic         o_sh_ready;
  logic [127:0] i_sh_data;
  logic [6:0]   i_sh_nonce;
  logic         o_im_valid;
  logic         i_im_handshake;
  logic [511:0] o_im_data;
  logic [6:0]   o_im_nonce;

  int n_checks = 0;
  int n_errors = 0;

  shuffle_unloader #(
    .nonce_width  (7),
    .explode_width(512)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_sh_valid    (i_sh_valid),
    .o_sh_ready    (o_sh_ready),
    .i_sh_data     (i_sh_data),
    .i_sh_nonce    (i_sh_nonce),
    .o_im_valid    (o_im_valid),
    .i_im_handshake(i_im_handshake),
    .o_im_data     (o_im_data),
    .o_im_nonce    (o_im_nonce)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat k of burst (a,b) is {64'h..ak, 64'h..bk}.
  function automatic logic [127:0] slice(input logic [3:0] a, input logic [3:0] b, input int k);
    return {56'h0, a, 4'(k), 56'h0, b, 4'(k)};
  endfunction

  function automatic logic [511:0] exp_word(input logic [3:0] a, input logic [3:0] b);
    logic [511:0] w;
    for (int j = 0; j < 4; j++) begin
      w[64*j +: 64]     = {56'h0, a, 4'(j)};
      w[64*(j+4) +: 64] = {56'h0, b, 4'(j)};
    end
    return w;
  endfunction

  task automatic send_burst(input logic [3:0] a, input logic [3:0] b, input logic [6:0] n,
                            input bit pulse2, input bit hs3);
    int w;
    w = 0;
    while (!o_sh_ready && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) check("ready_timeout", 1'b0, 1'b1);
    i_sh_valid = 1'b1;
    i_sh_nonce = n;
    i_sh_data  = slice(a, b, 0);
    step();
    i_sh_valid = 1'b0;
    i_sh_nonce = 7'h7f;
    for (int k = 1; k < 4; k++) begin
      i_sh_data  = slice(a, b, k);
      i_sh_valid = pulse2 && (k == 2);
      if (hs3 && k == 3) i_im_handshake = 1'b1;
      step();
    end
    i_sh_valid = 1'b0;
  endtask

  task automatic do_pop();
    i_im_handshake = 1'b1;
    step();
    i_im_handshake = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    i_sh_valid     = 1'b0;
    i_sh_data      = '0;
    i_sh_nonce     = '0;
    i_im_handshake = 1'b0;
    #3;
    check("rst_ready", o_sh_ready, 1'b0);
    check("rst_valid", o_im_valid, 1'b0);
    check("rst_data", o_im_data, '0);
    check("rst_nonce", o_im_nonce, 7'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", o_sh_ready, 1'b1);

    // Single burst: lanes A0..A3,B0..B3, valid at beat0+4.
    send_burst(4'hA, 4'hB, 7'h15, 1'b0, 1'b0);
    check("single_valid", o_im_valid, 1'b1);
    check("single_data", o_im_data,
          {64'hB3, 64'hB2, 64'hB1, 64'hB0, 64'hA3, 64'hA2, 64'hA1, 64'hA0});
    check("single_nonce", o_im_nonce, 7'h15);
    step();
    step();
    i_im_handshake = 1'b1;
    check("single_hold_valid", o_im_valid, 1'b1);
    check("single_hold_nonce", o_im_nonce, 7'h15);
    step();
    check("single_valid_drop", o_im_valid, 1'b0);
    i_im_handshake = 1'b0;
    step();
    step();
    check("single_empty", o_im_valid, 1'b0);

    // Stalled implode: two bursts fill the FIFO, the third waits for a pop.
    send_burst(4'h1, 4'h2, 7'h01, 1'b0, 1'b0);
    send_burst(4'h3, 4'h4, 7'h02, 1'b0, 1'b0);
    check("stall_full_ready", o_sh_ready, 1'b0);
    check("stall_w1_nonce", o_im_nonce, 7'h01);
    check("stall_w1_data", o_im_data, exp_word(4'h1, 4'h2));
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_ready", o_sh_ready, 1'b0);
    end
    i_im_handshake = 1'b1;
    #1;
    check("stall_no_comb_ready", o_sh_ready, 1'b0);
    step();
    check("stall_ready_after_pop", o_sh_ready, 1'b1);
    i_im_handshake = 1'b0;
    send_burst(4'h5, 4'h6, 7'h03, 1'b0, 1'b0);
    check("stall_w2_valid", o_im_valid, 1'b1);
    check("stall_w2_nonce", o_im_nonce, 7'h02);
    check("stall_w2_data", o_im_data, exp_word(4'h3, 4'h4));
    check("stall_full_again", o_sh_ready, 1'b0);
    do_pop();
    step();
    check("stall_w3_nonce", o_im_nonce, 7'h03);
    check("stall_w3_data", o_im_data, exp_word(4'h5, 4'h6));
    do_pop();
    step();
    check("stall_drained", o_im_valid, 1'b0);

    // Four-phase: held handshake blocks the queued second word.
    send_burst(4'h7, 4'h8, 7'h04, 1'b0, 1'b0);
    send_burst(4'h9, 4'h1, 7'h05, 1'b0, 1'b0);
    check("fp_w1_nonce", o_im_nonce, 7'h04);
    i_im_handshake = 1'b1;
    step();
    check("fp_drop", o_im_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("fp_hs_high", o_im_valid, 1'b0);
    end
    i_im_handshake = 1'b0;
    step();
    check("fp_idle", o_im_valid, 1'b0);
    step();
    check("fp_w2_valid", o_im_valid, 1'b1);
    check("fp_w2_nonce", o_im_nonce, 7'h05);
    do_pop();
    step();
    check("fp_drained", o_im_valid, 1'b0);

    // Valid pulsed during BEAT2 is ignored.
    send_burst(4'h2, 4'h3, 7'h06, 1'b1, 1'b0);
    check("ign_valid", o_im_valid, 1'b1);
    check("ign_nonce", o_im_nonce, 7'h06);
    check("ign_ready", o_sh_ready, 1'b1);
    step();
    check("ign_ready2", o_sh_ready, 1'b1);
    do_pop();
    step();
    check("ign_single_word", o_im_valid, 1'b0);

    // Reset mid-burst with one word queued.
    send_burst(4'h4, 4'h5, 7'h07, 1'b0, 1'b0);
    i_sh_valid = 1'b1;
    i_sh_nonce = 7'h08;
    i_sh_data  = slice(4'h6, 4'h6, 0);
    step();
    i_sh_valid = 1'b0;
    i_sh_data  = slice(4'h6, 4'h6, 1);
    step();
    i_sh_data = slice(4'h6, 4'h6, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", o_im_valid, 1'b0);
    check("mid_rst_ready", o_sh_ready, 1'b0);
    check("mid_rst_data", o_im_data, '0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", o_sh_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_rst_no_stale", o_im_valid, 1'b0);
    end

    // Push at BEAT3 coincides with pop at count=1.
    send_burst(4'hC, 4'hD, 7'h08, 1'b0, 1'b0);
    check("pp_w1_nonce", o_im_nonce, 7'h08);
    send_burst(4'hE, 4'hF, 7'h09, 1'b0, 1'b1);
    check("pp_valid_drop", o_im_valid, 1'b0);
    check("pp_count_one", o_sh_ready, 1'b1);
    i_im_handshake = 1'b0;
    step();
    step();
    check("pp_w2_valid", o_im_valid, 1'b1);
    check("pp_w2_nonce", o_im_nonce, 7'h09);
    check("pp_w2_data", o_im_data, exp_word(4'hE, 4'hF));
    do_pop();
    step();
    check("pp_drained", o_im_valid, 1'b0);
    check("pp_ready", o_sh_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
